// File: rtl/bus_rr_arbiter_pkg.sv
// Shared constants and types for the round-robin bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_rr_arbiter_pkg;

    // Field widths of one master's request.
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int WR_W   = 4;
    localparam int EN_W   = 1;

    localparam int DEFAULT_NMASTERS       = 3;
    localparam int DEFAULT_TIMEOUT_CYCLES = 255;

    // Arbiter FSM: IDLE arbitrates, BUSY owns the slave for one transfer.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first requester after 'last', wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module rr_pick #(
    parameter int NMASTERS = 3,
    parameter int IDX_W    = 2
) (
    input  logic [NMASTERS-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic [NMASTERS-1:0] grant
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Scan offsets 1..NMASTERS from last so 'last' itself is checked at the very end.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NMASTERS; k++) begin
            idx = IDX_W'((int'(last) + k) % NMASTERS);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter granting NMASTERS bus masters access to one slave, with timeout.
// Latency: request at cycle t drives slave_enable at t+1; ready/error pulse in the slave-ready cycle.
// Backpressure: masters hold master_enable until ready/error; requests seen while BUSY wait for the next IDLE.
module bus_rr_arbiter
    import bus_rr_arbiter_pkg::*;
#(
    parameter int NMASTERS       = DEFAULT_NMASTERS,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W*NMASTERS-1:0]   master_address,
    input  logic [DATA_W*NMASTERS-1:0]   master_data_i,
    input  logic [WR_W*NMASTERS-1:0]     master_wr,
    input  logic [EN_W*NMASTERS-1:0]     master_enable,
    output logic [DATA_W-1:0]            master_data_o,
    output logic [NMASTERS-1:0]          master_ready,
    output logic [NMASTERS-1:0]          master_error,
    input  logic [DATA_W-1:0]            slave_data_i,
    input  logic                         slave_ready,
    input  logic                         slave_error,
    output logic [ADDR_W-1:0]            slave_address,
    output logic [DATA_W-1:0]            slave_data_o,
    output logic [WR_W-1:0]              slave_wr,
    output logic                         slave_enable
);

    localparam int IDX_W = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Counter value seen in the last BUSY cycle before a timeout is declared.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    // After reset the highest index is "last", so master 0 has first priority.
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NMASTERS - 1);

    state_t              state, state_d;
    logic [NMASTERS-1:0] grant, grant_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [IDX_W-1:0]    last, last_d;

    logic [NMASTERS-1:0] pick;
    logic [IDX_W-1:0]    g_idx;
    logic                gnt_en;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [WR_W-1:0]     sel_wr;
    logic                ready_fire;
    logic                error_fire;

    rr_pick #(
        .NMASTERS (NMASTERS),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req   (master_enable),
        .last  (last),
        .grant (pick)
    );

    // One-hot grant to index plus AND-OR mux of the granted master's request fields.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_wr   = '0;
        g_idx    = '0;
        for (int i = 0; i < NMASTERS; i++) begin
            if (grant[i]) begin
                sel_addr = sel_addr | master_address[i*ADDR_W +: ADDR_W];
                sel_data = sel_data | master_data_i[i*DATA_W +: DATA_W];
                sel_wr   = sel_wr   | master_wr[i*WR_W +: WR_W];
                g_idx    = IDX_W'(i);
            end
        end
        gnt_en = |(master_enable & grant);
    end

    // Next-state logic: arbitrate in IDLE; in BUSY abort, complete, time out or keep counting.
    always_comb begin
        state_d    = state;
        grant_d    = grant;
        cnt_d      = cnt;
        last_d     = last;
        ready_fire = 1'b0;
        error_fire = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|master_enable) begin
                    state_d = ST_BUSY;
                    grant_d = pick;
                    cnt_d   = '0;
                end
            end
            ST_BUSY: begin
                if (!gnt_en) begin
                    // Granted master withdrew: silent abort, priority pointer untouched.
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else if (slave_ready) begin
                    // Ready beats a coincident timeout.
                    ready_fire = 1'b1;
                    error_fire = slave_error;
                    last_d     = g_idx;
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                end else if (cnt == CNT_LAST) begin
                    error_fire = 1'b1;
                    last_d     = g_idx;
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Output drive: everything zero under reset or in IDLE; BUSY forwards the granted request.
    always_comb begin
        slave_enable  = 1'b0;
        slave_address = '0;
        slave_data_o  = '0;
        slave_wr      = '0;
        master_ready  = '0;
        master_error  = '0;
        master_data_o = '0;
        if (!rst && state == ST_BUSY) begin
            slave_enable  = 1'b1;
            slave_address = sel_addr;
            slave_data_o  = sel_data;
            slave_wr      = sel_wr;
            master_ready  = grant & {NMASTERS{ready_fire}};
            master_error  = grant & {NMASTERS{error_fire}};
            if (ready_fire) begin
                master_data_o = slave_data_i;
            end
        end
    end

    // State, grant, busy counter and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            grant <= '0;
            cnt   <= '0;
            last  <= LAST_RST;
        end else begin
            state <= state_d;
            grant <= grant_d;
            cnt   <= cnt_d;
            last  <= last_d;
        end
    end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Bench for bus_rr_arbiter: cycle model compared every cycle plus directed literal checks.
// Latency: model follows request -> grant next cycle -> ready/error in the slave-ready cycle.
// Backpressure: stimulus holds master_enable until the ready/error cycle.
module tb_bus_rr_arbiter;

    localparam int NM = 3;
    localparam int TO = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [32*NM-1:0]  master_address;
    logic [32*NM-1:0]  master_data_i;
    logic [4*NM-1:0]   master_wr;
    logic [NM-1:0]     master_enable;
    logic [31:0]       master_data_o;
    logic [NM-1:0]     master_ready;
    logic [NM-1:0]     master_error;
    logic [31:0]       slave_data_i;
    logic              slave_ready;
    logic              slave_error;
    logic [31:0]       slave_address;
    logic [31:0]       slave_data_o;
    logic [3:0]        slave_wr;
    logic              slave_enable;

    int checks = 0;
    int errors = 0;

    bus_rr_arbiter #(
        .NMASTERS       (NM),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .master_address (master_address),
        .master_data_i  (master_data_i),
        .master_wr      (master_wr),
        .master_enable  (master_enable),
        .master_data_o  (master_data_o),
        .master_ready   (master_ready),
        .master_error   (master_error),
        .slave_data_i   (slave_data_i),
        .slave_ready    (slave_ready),
        .slave_error    (slave_error),
        .slave_address  (slave_address),
        .slave_data_o   (slave_data_o),
        .slave_wr       (slave_wr),
        .slave_enable   (slave_enable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // Tracks who owns the bus and for how many cycles; outputs derived per cycle.
    int m_busy = 0, m_owner = 0, m_last = NM - 1, m_cnt = 0;
    int n_busy = 0, n_owner = 0, n_last = NM - 1, n_cnt = 0;
    logic          e_sen;
    logic [31:0]   e_addr, e_sdat, e_dout;
    logic [3:0]    e_wr;
    logic [NM-1:0] e_rdy, e_err;

    always @(negedge clk) begin
        e_sen = 1'b0; e_addr = '0; e_sdat = '0; e_wr = '0;
        e_rdy = '0; e_err = '0; e_dout = '0;
        n_busy = m_busy; n_owner = m_owner; n_last = m_last; n_cnt = m_cnt;
        if (rst) begin
            n_busy = 0;
            n_cnt  = 0;
            n_last = NM - 1;
        end else if (m_busy == 0) begin
            if (master_enable != '0) begin
                for (int k = 1; k <= NM; k++) begin
                    if (n_busy == 0 && master_enable[(m_last + k) % NM]) begin
                        n_owner = (m_last + k) % NM;
                        n_busy  = 1;
                        n_cnt   = 1;
                    end
                end
            end
        end else begin
            e_sen  = 1'b1;
            e_addr = master_address[m_owner*32 +: 32];
            e_sdat = master_data_i[m_owner*32 +: 32];
            e_wr   = master_wr[m_owner*4 +: 4];
            if (!master_enable[m_owner]) begin
                n_busy = 0;
            end else if (slave_ready) begin
                e_rdy[m_owner] = 1'b1;
                e_err[m_owner] = slave_error;
                e_dout         = slave_data_i;
                n_last         = m_owner;
                n_busy         = 0;
            end else if (m_cnt == TO) begin
                e_err[m_owner] = 1'b1;
                n_last         = m_owner;
                n_busy         = 0;
            end else begin
                n_cnt = m_cnt + 1;
            end
        end
        chk("model_slave_enable",  {31'b0, slave_enable}, {31'b0, e_sen});
        chk("model_slave_address", slave_address, e_addr);
        chk("model_slave_data_o",  slave_data_o, e_sdat);
        chk("model_slave_wr",      {28'b0, slave_wr}, {28'b0, e_wr});
        chk("model_master_ready",  {29'b0, master_ready}, {29'b0, e_rdy});
        chk("model_master_error",  {29'b0, master_error}, {29'b0, e_err});
        chk("model_master_data_o", master_data_o, e_dout);
    end

    always @(posedge clk) begin
        m_busy = n_busy; m_owner = n_owner; m_last = n_last; m_cnt = n_cnt;
    end

    // ---------------- directed stimulus ----------------
    logic [2:0] fair_exp [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

    initial begin
        rst           = 1'b1;
        master_enable = 3'b111;
        slave_ready   = 1'b1;
        slave_error   = 1'b1;
        slave_data_i  = 32'hDEAD_BEEF;
        for (int i = 0; i < NM; i++) begin
            master_address[i*32 +: 32] = 32'hA000_0000 + i;
            master_data_i[i*32 +: 32]  = 32'hD000_0000 + i;
            master_wr[i*4 +: 4]        = 4'(i + 1);
        end

        // Reset: outputs held at zero despite active requests and slave ready.
        step(); step(); #2;
        chk("rst_slave_enable", {31'b0, slave_enable}, 32'd0);
        chk("rst_slave_address", slave_address, 32'd0);
        chk("rst_master_ready", {29'b0, master_ready}, 32'd0);
        chk("rst_master_error", {29'b0, master_error}, 32'd0);
        chk("rst_master_data_o", master_data_o, 32'd0);

        // Single request from master 1, ready in cycle 3.
        step(); rst = 1'b0; master_enable = '0; slave_ready = 1'b0; slave_error = 1'b0; slave_data_i = '0;
        step(); master_enable = 3'b010; #2;
        chk("single_c0_idle", {31'b0, slave_enable}, 32'd0);
        step(); #2;
        chk("single_c1_sen", {31'b0, slave_enable}, 32'd1);
        chk("single_c1_addr", slave_address, 32'hA000_0001);
        chk("single_c1_data", slave_data_o, 32'hD000_0001);
        chk("single_c1_wr", {28'b0, slave_wr}, 32'd2);
        step(); #2;
        chk("single_c2_sen", {31'b0, slave_enable}, 32'd1);
        step(); slave_ready = 1'b1; slave_data_i = 32'h1234_5678; #2;
        chk("single_c3_sen", {31'b0, slave_enable}, 32'd1);
        chk("single_c3_ready", {29'b0, master_ready}, 32'b010);
        chk("single_c3_error", {29'b0, master_error}, 32'd0);
        chk("single_c3_dout", master_data_o, 32'h1234_5678);
        step(); slave_ready = 1'b0; master_enable = '0; #2;
        chk("single_c4_idle", {31'b0, slave_enable}, 32'd0);
        chk("single_c4_dout_zero", master_data_o, 32'd0);

        // Fairness after reset: all request, ready one cycle after each grant.
        step(); rst = 1'b1;
        step(); rst = 1'b0; master_enable = 3'b111;
        for (int c = 0; c < 18; c++) begin
            if (c > 0) step();
            slave_ready = (c % 3 == 2);
            #2;
            if (c % 3 == 0) chk("fair_idle_gap", {31'b0, slave_enable}, 32'd0);
            else            chk("fair_busy", {31'b0, slave_enable}, 32'd1);
            if (c % 3 == 2) chk("fair_grant_order", {29'b0, master_ready}, {29'b0, fair_exp[c/3]});
        end
        step(); master_enable = '0; slave_ready = 1'b0;

        // Timeout on master 2, then master 0 wins and completes with a slave error.
        step(); master_enable = 3'b100;
        for (int b = 1; b <= 3; b++) begin
            step(); #2;
            chk("to_busy", {31'b0, slave_enable}, 32'd1);
            chk("to_no_err_yet", {29'b0, master_error}, 32'd0);
        end
        step(); #2;
        chk("to_error", {29'b0, master_error}, 32'b100);
        chk("to_no_ready", {29'b0, master_ready}, 32'd0);
        step(); master_enable = 3'b101; #2;
        chk("to_idle_after", {31'b0, slave_enable}, 32'd0);
        chk("to_err_cleared", {29'b0, master_error}, 32'd0);
        step(); slave_ready = 1'b1; slave_error = 1'b1; slave_data_i = 32'hCAFE_0000; #2;
        chk("to_next_grant_m0", slave_address, 32'hA000_0000);
        chk("serr_ready", {29'b0, master_ready}, 32'b001);
        chk("serr_error", {29'b0, master_error}, 32'b001);
        step(); slave_ready = 1'b0; slave_error = 1'b0; master_enable = '0;

        // Abort by master 1; pointer must remain at master 0.
        step(); master_enable = 3'b010;
        step(); #2;
        chk("abort_busy_addr", slave_address, 32'hA000_0001);
        step(); master_enable = '0; #2;
        chk("abort_no_ready", {29'b0, master_ready}, 32'd0);
        chk("abort_no_error", {29'b0, master_error}, 32'd0);
        step(); #2;
        chk("abort_idle", {31'b0, slave_enable}, 32'd0);

        // Masters 0 and 1 contend: master 1 follows last=0; ready lands in the timeout cycle.
        step(); master_enable = 3'b011;
        for (int b = 1; b <= 3; b++) begin
            step(); #2;
            chk("tie_grant_m1", slave_address, 32'hA000_0001);
        end
        step(); slave_ready = 1'b1; slave_data_i = 32'h0BAD_F00D; #2;
        chk("tie_ready", {29'b0, master_ready}, 32'b010);
        chk("tie_no_error", {29'b0, master_error}, 32'd0);
        chk("tie_dout", master_data_o, 32'h0BAD_F00D);
        step(); slave_ready = 1'b0; master_enable = '0;

        // Reset while master 2 is BUSY; afterwards master 0 beats master 2.
        step(); master_enable = 3'b100;
        step(); rst = 1'b1; #2;
        chk("rstbusy_sen", {31'b0, slave_enable}, 32'd0);
        chk("rstbusy_addr", slave_address, 32'd0);
        step(); rst = 1'b0; master_enable = 3'b101; #2;
        chk("rstbusy_after_sen", {31'b0, slave_enable}, 32'd0);
        chk("rstbusy_after_ready", {29'b0, master_ready}, 32'd0);
        chk("rstbusy_after_error", {29'b0, master_error}, 32'd0);
        step(); slave_ready = 1'b1; #2;
        chk("rstbusy_m0_wins", slave_address, 32'hA000_0000);
        chk("rstbusy_m0_ready", {29'b0, master_ready}, 32'b001);
        step(); slave_ready = 1'b0; master_enable = '0;
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
